// File: rtl/neuron_pkg.sv
// Constants and state types shared by the feature collector
// and the Neuron_*_FL bank.
package neuron_pkg;

   localparam int BROJ_ZNACAJKI  = 60;
   localparam int SIRINA_UZORKA  = 16;
   localparam int SIRINA_OKVIRA  = BROJ_ZNACAJKI * SIRINA_UZORKA;
   localparam int SIRINA_BROJACA = 16;
   localparam int SIRINA_INDEKSA = $clog2(BROJ_ZNACAJKI);

   typedef enum logic {
      PUNJENJE,
      PUNO
   } sklop_e;

   typedef enum logic {
      PRAZNO,
      VAZECE
   } izlaz_e;

   // Sign-magnitude negative values are forced to zero.
   function automatic logic [SIRINA_UZORKA-1:0] stegni(
      input logic [SIRINA_UZORKA-1:0] x
   );
      return x[SIRINA_UZORKA-1] ? '0 : x;
   endfunction

endpackage

// File: rtl/uzorak_sakupljac.sv
// Packs 60 16-bit features into one double-buffered 960-bit frame.
// Optional clamp of negative features: define UZORAK_STEZANJE_EN.
module uzorak_sakupljac
   import neuron_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic [SIRINA_UZORKA-1:0]  ulaz_podatak,
   input  logic                      ulaz_valid,
   input  logic                      ulaz_zadnji,
   output logic                      ulaz_ready,
   output logic [SIRINA_OKVIRA-1:0]  uzorak,
   output logic                      uzorak_valid,
   input  logic                      uzorak_ready,
   output logic                      greska,
`ifdef UZORAK_STEZANJE_EN
   output logic                      stegnuto,
`endif
   output logic [SIRINA_BROJACA-1:0] broj_okvira,
   output logic [SIRINA_BROJACA-1:0] broj_gresaka
);

   localparam logic [SIRINA_INDEKSA-1:0] ZADNJI_SLOT =
      SIRINA_INDEKSA'(BROJ_ZNACAJKI - 1);

   sklop_e                    sklop_q, sklop_d;
   izlaz_e                    izlaz_q, izlaz_d;
   logic [SIRINA_INDEKSA-1:0] index_q, index_d;
   logic [SIRINA_OKVIRA-1:0]  asm_q, asm_d;
   logic [SIRINA_OKVIRA-1:0]  out_q, out_d;
   logic                      greska_q, greska_d;
   logic [SIRINA_BROJACA-1:0] okviri_q, okviri_d;
   logic [SIRINA_BROJACA-1:0] greske_q, greske_d;
   logic                      stegnuto_q, stegnuto_d;

   logic                      hs;
   logic                      prihvat;
   logic [SIRINA_UZORKA-1:0]  podatak;

   // Handshake qualifiers and the value actually stored.
   always_comb begin
      hs      = (izlaz_q == VAZECE) && uzorak_ready;
      prihvat = ulaz_valid && (sklop_q == PUNJENJE);
`ifdef UZORAK_STEZANJE_EN
      podatak = stegni(ulaz_podatak);
`else
      podatak = ulaz_podatak;
`endif
   end

   // Next-state logic for both FSMs, buffers and counters.
   always_comb begin
      sklop_d    = sklop_q;
      izlaz_d    = izlaz_q;
      index_d    = index_q;
      asm_d      = asm_q;
      out_d      = out_q;
      greska_d   = 1'b0;
      okviri_d   = okviri_q;
      greske_d   = greske_q;
      stegnuto_d = 1'b0;

      if (hs) begin
         okviri_d = okviri_q + SIRINA_BROJACA'(1);
         izlaz_d  = PRAZNO;
      end

      unique case (sklop_q)
         PUNJENJE: begin
            if (prihvat) begin
               stegnuto_d = ulaz_podatak[SIRINA_UZORKA-1];
               asm_d[int'(index_q)*SIRINA_UZORKA +: SIRINA_UZORKA] =
                  podatak;
               if (index_q == ZADNJI_SLOT) begin
                  greska_d = !ulaz_zadnji;
                  if ((izlaz_q == PRAZNO) || hs) begin
                     out_d   = asm_d;
                     izlaz_d = VAZECE;
                     index_d = '0;
                  end else begin
                     sklop_d = PUNO;
                  end
               end else if (ulaz_zadnji) begin
                  // Short frame: drop what was collected.
                  index_d  = '0;
                  greska_d = 1'b1;
               end else begin
                  index_d = index_q + SIRINA_INDEKSA'(1);
               end
            end
         end
         PUNO: begin
            if (hs) begin
               out_d   = asm_q;
               izlaz_d = VAZECE;
               index_d = '0;
               sklop_d = PUNJENJE;
            end
         end
      endcase

      if (greska_d) begin
         greske_d = greske_q + SIRINA_BROJACA'(1);
      end
   end

   // State registers; reset drops any partial frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sklop_q    <= PUNJENJE;
         izlaz_q    <= PRAZNO;
         index_q    <= '0;
         asm_q      <= '0;
         out_q      <= '0;
         greska_q   <= 1'b0;
         okviri_q   <= '0;
         greske_q   <= '0;
         stegnuto_q <= 1'b0;
      end else begin
         sklop_q    <= sklop_d;
         izlaz_q    <= izlaz_d;
         index_q    <= index_d;
         asm_q      <= asm_d;
         out_q      <= out_d;
         greska_q   <= greska_d;
         okviri_q   <= okviri_d;
         greske_q   <= greske_d;
         stegnuto_q <= stegnuto_d;
      end
   end

   // Ready is held low while reset is asserted.
   always_comb begin
      ulaz_ready   = (sklop_q == PUNJENJE) && !rst;
      uzorak       = out_q;
      uzorak_valid = (izlaz_q == VAZECE);
      greska       = greska_q;
      broj_okvira  = okviri_q;
      broj_gresaka = greske_q;
   end

`ifdef UZORAK_STEZANJE_EN
   assign stegnuto = stegnuto_q;
`else
   logic unused_stegnuto;
   assign unused_stegnuto = stegnuto_q;
`endif

endmodule

// File: tb/tb_uzorak_sakupljac.sv
// Random and directed stimulus for uzorak_sakupljac, checked
// against a frame-level queue model.
module tb_uzorak_sakupljac;
   import neuron_pkg::*;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [15:0]  ulaz_podatak = '0;
   logic         ulaz_valid = 1'b0;
   logic         ulaz_zadnji = 1'b0;
   logic         ulaz_ready;
   logic [959:0] uzorak;
   logic         uzorak_valid;
   logic         uzorak_ready = 1'b0;
   logic         greska;
   logic         stegnuto;
   logic [15:0]  broj_okvira;
   logic [15:0]  broj_gresaka;

   int total = 0;
   int bad   = 0;

   uzorak_sakupljac dut (
      .clk          (clk),
      .rst          (rst),
      .ulaz_podatak (ulaz_podatak),
      .ulaz_valid   (ulaz_valid),
      .ulaz_zadnji  (ulaz_zadnji),
      .ulaz_ready   (ulaz_ready),
      .uzorak       (uzorak),
      .uzorak_valid (uzorak_valid),
      .uzorak_ready (uzorak_ready),
      .greska       (greska),
`ifdef UZORAK_STEZANJE_EN
      .stegnuto     (stegnuto),
`endif
      .broj_okvira  (broj_okvira),
      .broj_gresaka (broj_gresaka)
   );

`ifndef UZORAK_STEZANJE_EN
   assign stegnuto = 1'b0;
`endif

   always #5 clk = ~clk;

   // Reference model: collected words, pending frame, output frame.
   logic [15:0]  cur[$];
   logic [959:0] pend;
   bit           pend_v;
   logic [959:0] m_out;
   bit           m_ov;
   logic [15:0]  m_ok;
   logic [15:0]  m_ek;
   bit           m_err;
   bit           m_cl;

   task automatic provjeri(input string tag,
                           input logic [239:0] got,
                           input logic [239:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      cur.delete();
      pend   = '0;
      pend_v = 0;
      m_out  = '0;
      m_ov   = 0;
      m_ok   = '0;
      m_ek   = '0;
      m_err  = 0;
      m_cl   = 0;
   endtask

   task automatic model_step();
      bit hs, acc, ov_old;
      logic [15:0]  w;
      logic [959:0] f;
      hs     = m_ov && uzorak_ready;
      acc    = ulaz_valid && !pend_v;
      ov_old = m_ov;
      m_err  = 0;
      m_cl   = 0;
      if (hs) begin
         m_ok++;
         m_ov = 0;
         if (pend_v) begin
            m_out  = pend;
            m_ov   = 1;
            pend_v = 0;
         end
      end
      if (acc) begin
         w = ulaz_podatak;
`ifdef UZORAK_STEZANJE_EN
         if (w[15]) begin
            w    = '0;
            m_cl = 1;
         end
`endif
         if (ulaz_zadnji && cur.size() < 59) begin
            cur.delete();
            m_err = 1;
         end else begin
            cur.push_back(w);
            if (cur.size() == 60) begin
               if (!ulaz_zadnji) m_err = 1;
               for (int k = 0; k < 60; k++) f[16*k +: 16] = cur[k];
               cur.delete();
               if (!ov_old || hs) begin
                  m_out = f;
                  m_ov  = 1;
               end else begin
                  pend   = f;
                  pend_v = 1;
               end
            end
         end
      end
      if (m_err) m_ek++;
   endtask

   task automatic check_all();
      provjeri("ulaz_ready", 240'(ulaz_ready), 240'(!pend_v));
      provjeri("uzorak_valid", 240'(uzorak_valid), 240'(m_ov));
      for (int q = 0; q < 4; q++)
         provjeri($sformatf("uzorak[%0d]", q),
                  uzorak[240*q +: 240], m_out[240*q +: 240]);
      provjeri("greska", 240'(greska), 240'(m_err));
      provjeri("broj_okvira", 240'(broj_okvira), 240'(m_ok));
      provjeri("broj_gresaka", 240'(broj_gresaka), 240'(m_ek));
      provjeri("stegnuto", 240'(stegnuto), 240'(m_cl));
   endtask

   task automatic cyc(input bit v, input logic [15:0] d,
                      input bit z, input bit r);
      ulaz_valid   = v;
      ulaz_podatak = d;
      ulaz_zadnji  = z;
      uzorak_ready = r;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      model_reset();
      provjeri("rst_ready", 240'(ulaz_ready), 240'(0));
      provjeri("rst_valid", 240'(uzorak_valid), 240'(0));
      provjeri("rst_uzorak_lo", uzorak[239:0], 240'(0));
      provjeri("rst_uzorak_hi", uzorak[959:720], 240'(0));
      provjeri("rst_greska", 240'(greska), 240'(0));
      provjeri("rst_okvira", 240'(broj_okvira), 240'(0));
      provjeri("rst_gresaka", 240'(broj_gresaka), 240'(0));
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_all();
   endtask

   initial begin
      logic [15:0] d;
      bit z;
      int rmode;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_all();

      // Basic frame.
      for (int k = 0; k < 60; k++) cyc(1, 16'(k + 1), k == 59, 1);
      provjeri("basic_lo", 240'(uzorak[15:0]), 240'(16'h0001));
      provjeri("basic_hi", 240'(uzorak[959:944]), 240'(16'h003C));
      for (int k = 0; k < 3; k++) cyc(0, '0, 0, 1);
      provjeri("basic_cnt", 240'(broj_okvira), 240'(1));

      // Back-pressure: two frames held, then drained.
      for (int k = 0; k < 120; k++)
         cyc(1, 16'($urandom), (k % 60) == 59, 0);
      provjeri("bp_ready", 240'(ulaz_ready), 240'(0));
      for (int k = 0; k < 4; k++) cyc(1, 16'h1111, 0, 0);
      cyc(0, '0, 0, 1);
      provjeri("bp_ready2", 240'(ulaz_ready), 240'(1));
      provjeri("bp_valid2", 240'(uzorak_valid), 240'(1));
      for (int k = 0; k < 3; k++) cyc(0, '0, 0, 1);

      // Back-to-back frames.
      for (int k = 0; k < 180; k++)
         cyc(1, 16'($urandom), (k % 60) == 59, 1);
      cyc(0, '0, 0, 1);

      // Early last on feature 10, then a clean frame.
      for (int k = 0; k < 10; k++) cyc(1, 16'(k), k == 9, 1);
      provjeri("early_greska", 240'(greska), 240'(1));
      for (int k = 0; k < 60; k++) cyc(1, 16'(k + 100), k == 59, 1);
      cyc(0, '0, 0, 1);

      // Missing last on slot 59.
      for (int k = 0; k < 60; k++) cyc(1, 16'(k), 0, 1);
      cyc(0, '0, 0, 1);

      // Reset mid-frame, then a clean A5A5 frame.
      for (int k = 0; k < 30; k++) cyc(1, 16'h7777, 0, 1);
      do_reset();
      for (int k = 0; k < 60; k++) cyc(1, 16'hA5A5, k == 59, 1);
      cyc(0, '0, 0, 1);

      // Negative feature value in slot 0.
      for (int k = 0; k < 60; k++)
         cyc(1, (k == 0) ? 16'h8123 : 16'(k), k == 59, 0);
`ifdef UZORAK_STEZANJE_EN
      provjeri("clamp_lo", 240'(uzorak[15:0]), 240'(16'h0000));
`else
      provjeri("clamp_lo", 240'(uzorak[15:0]), 240'(16'h8123));
`endif
      cyc(0, '0, 0, 1);

      // Random traffic with varying consumer pressure.
      for (int blk = 0; blk < 30; blk++) begin
         rmode = $urandom_range(0, 3);
         for (int k = 0; k < 100; k++) begin
            d = 16'($urandom);
            if (cur.size() == 59) z = ($urandom % 10) != 0;
            else z = ($urandom % 100) == 0;
            cyc(($urandom % 4) != 0, d, z,
                rmode == 0 ? 1'b1 :
                rmode == 1 ? 1'b0 : (($urandom % 3) != 0));
         end
      end
      for (int k = 0; k < 5; k++) cyc(0, '0, 0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got=0 exp=1");
      $fatal(1, "timeout");
   end

endmodule
